// File: rtl/jtag_tap_master_if.sv
// Command/response channel between on-chip debug logic and the JTAG TAP master.
interface jtag_tap_master_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_W      = $clog2(DATA_WIDTH)
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [LEN_W-1:0]      cmd_len;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/jtag_tap_master.sv
// Host-side JTAG driver: turns TAP reset / IR scan / DR scan / run-idle commands into
// TCLK/TMS/TDI slot sequences and captures TDO during shift slots.
module jtag_tap_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned LEN_W      = $clog2(DATA_WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    jtag_tap_master_if.slave bus,
    output logic             TCLK,
    output logic             TRST,
    output logic             TMS,
    output logic             TDI,
    input  logic             TDO
);
    localparam int unsigned N_W   = LEN_W + 1;
    localparam int unsigned CNT_W = LEN_W + 3;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_RUN   = 2'd3;

    typedef enum logic [1:0] {ST_BOOT, ST_IDLE, ST_LOW, ST_HIGH} state_t;

    state_t                r_state, w_state_nx;
    logic [DIV_W-1:0]      r_div, w_div_nx;
    logic [1:0]            r_op, w_op_nx;
    logic [N_W-1:0]        r_n, w_n_nx;
    logic [CNT_W-1:0]      r_slot, w_slot_nx;
    logic [CNT_W-1:0]      r_total, w_total_nx;
    logic                  r_init, w_init_nx;
    logic [DATA_WIDTH-1:0] r_sh, w_sh_nx;
    logic [DATA_WIDTH-1:0] r_cap, w_cap_nx;
    logic                  r_tclk, w_tclk_nx;
    logic                  r_tms, w_tms_nx;
    logic                  r_tdi, w_tdi_nx;
    logic                  r_trst, w_trst_nx;
    logic                  r_ready, w_ready_nx;
    logic                  r_rsp_valid, w_rsp_valid_nx;
    logic [DATA_WIDTH-1:0] r_rsp_data, w_rsp_data_nx;

    logic                  w_start;
    logic [1:0]            w_op_sel;
    logic [N_W-1:0]        w_n_sel;
    logic [CNT_W-1:0]      w_slot_sel;
    logic [DATA_WIDTH-1:0] w_sh_src;
    logic [N_W-1:0]        w_cmd_n;
    logic                  w_phase_end;
    logic                  w_last;
    logic                  w_cur_shift;

    // Slot where TDI drives / TDO is captured: between the fixed pre- and post-amble slots.
    function automatic logic slot_shift(input logic [1:0] op, input logic [N_W-1:0] n,
                                        input logic [CNT_W-1:0] s);
        logic [CNT_W-1:0] pre;
        pre = (op == OP_IR) ? CNT_W'(4) : CNT_W'(3);
        slot_shift = ((op == OP_IR) || (op == OP_DR)) && (s >= pre) && (s < pre + CNT_W'(n));
    endfunction

    function automatic logic slot_tms(input logic [1:0] op, input logic [N_W-1:0] n,
                                      input logic [CNT_W-1:0] s);
        logic [CNT_W-1:0] pre;
        logic [CNT_W-1:0] last;
        pre  = (op == OP_IR) ? CNT_W'(4) : CNT_W'(3);
        last = pre + CNT_W'(n) - CNT_W'(1);
        case (op)
            OP_RESET: slot_tms = (s < CNT_W'(5));
            OP_RUN:   slot_tms = 1'b0;
            default:  slot_tms = (s < pre) ? (s < pre - CNT_W'(2))
                                           : ((s == last) || (s == last + CNT_W'(1)));
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] slot_total(input logic [1:0] op, input logic [N_W-1:0] n);
        case (op)
            OP_RESET: slot_total = CNT_W'(6);
            OP_IR:    slot_total = CNT_W'(n) + CNT_W'(6);
            OP_DR:    slot_total = CNT_W'(n) + CNT_W'(5);
            default:  slot_total = CNT_W'(n);
        endcase
    endfunction

    assign w_cmd_n     = (bus.cmd_len == '0) ? N_W'(DATA_WIDTH) : N_W'(bus.cmd_len);
    assign w_phase_end = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last      = (r_slot == r_total - CNT_W'(1));
    assign w_cur_shift = slot_shift(r_op, r_n, r_slot);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_BOOT;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_BOOT: w_state_nx = ST_LOW;
            ST_IDLE: if (bus.cmd_valid) w_state_nx = ST_LOW;
            ST_LOW:  if (w_phase_end) w_state_nx = ST_HIGH;
            ST_HIGH: if (w_phase_end) w_state_nx = w_last ? ST_IDLE : ST_LOW;
            default: w_state_nx = ST_BOOT;
        endcase
    end

    // Next values of pins and datapath; a slot start loads TMS/TDI for w_slot_sel.
    always_comb begin
        w_div_nx       = w_phase_end ? '0 : r_div + DIV_W'(1);
        w_op_nx        = r_op;
        w_n_nx         = r_n;
        w_slot_nx      = r_slot;
        w_total_nx     = r_total;
        w_init_nx      = r_init;
        w_sh_nx        = r_sh;
        w_cap_nx       = r_cap;
        w_tclk_nx      = r_tclk;
        w_tms_nx       = r_tms;
        w_tdi_nx       = r_tdi;
        w_trst_nx      = r_trst;
        w_ready_nx     = r_ready;
        w_rsp_valid_nx = 1'b0;
        w_rsp_data_nx  = r_rsp_data;
        w_start        = 1'b0;
        w_op_sel       = r_op;
        w_n_sel        = r_n;
        w_slot_sel     = r_slot + CNT_W'(1);
        w_sh_src       = r_sh;

        case (r_state)
            ST_BOOT: begin
                w_start    = 1'b1;
                w_op_sel   = OP_RESET;
                w_slot_sel = '0;
                w_op_nx    = OP_RESET;
                w_slot_nx  = '0;
                w_total_nx = slot_total(OP_RESET, r_n);
                w_init_nx  = 1'b1;
                w_trst_nx  = 1'b0;
                w_div_nx   = '0;
            end
            ST_IDLE: begin
                w_div_nx = '0;
                if (bus.cmd_valid) begin
                    w_start    = 1'b1;
                    w_op_sel   = bus.cmd_op;
                    w_n_sel    = w_cmd_n;
                    w_slot_sel = '0;
                    w_op_nx    = bus.cmd_op;
                    w_n_nx     = w_cmd_n;
                    w_slot_nx  = '0;
                    w_total_nx = slot_total(bus.cmd_op, w_cmd_n);
                    w_init_nx  = 1'b0;
                    w_sh_src   = bus.cmd_data << (N_W'(DATA_WIDTH) - w_cmd_n);
                    w_sh_nx    = w_sh_src;
                    w_cap_nx   = '0;
                    w_trst_nx  = (bus.cmd_op == OP_RESET);
                    w_ready_nx = 1'b0;
                end
            end
            ST_LOW: begin
                if (w_phase_end) begin
                    w_tclk_nx = 1'b1;
                    if (w_cur_shift) w_cap_nx = {r_cap[DATA_WIDTH-2:0], TDO};
                end
            end
            ST_HIGH: begin
                if (w_phase_end) begin
                    w_tclk_nx = 1'b0;
                    if (w_last) begin
                        w_tms_nx   = 1'b0;
                        w_tdi_nx   = 1'b0;
                        w_trst_nx  = 1'b0;
                        w_ready_nx = 1'b1;
                        w_init_nx  = 1'b0;
                        if (!r_init) begin
                            w_rsp_valid_nx = 1'b1;
                            w_rsp_data_nx  = r_cap;
                        end
                    end else begin
                        w_start   = 1'b1;
                        w_slot_nx = r_slot + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase

        if (w_start) begin
            w_tms_nx = slot_tms(w_op_sel, w_n_sel, w_slot_sel);
            w_tdi_nx = 1'b0;
            if (slot_shift(w_op_sel, w_n_sel, w_slot_sel)) begin
                w_tdi_nx = w_sh_src[DATA_WIDTH-1];
                w_sh_nx  = w_sh_src << 1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div       <= '0;
            r_op        <= OP_RESET;
            r_n         <= '0;
            r_slot      <= '0;
            r_total     <= '0;
            r_init      <= 1'b1;
            r_sh        <= '0;
            r_cap       <= '0;
            r_tclk      <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_trst      <= 1'b1;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_div       <= w_div_nx;
            r_op        <= w_op_nx;
            r_n         <= w_n_nx;
            r_slot      <= w_slot_nx;
            r_total     <= w_total_nx;
            r_init      <= w_init_nx;
            r_sh        <= w_sh_nx;
            r_cap       <= w_cap_nx;
            r_tclk      <= w_tclk_nx;
            r_tms       <= w_tms_nx;
            r_tdi       <= w_tdi_nx;
            r_trst      <= w_trst_nx;
            r_ready     <= w_ready_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp_data  <= w_rsp_data_nx;
        end
    end

    assign TCLK          = r_tclk;
    assign TMS           = r_tms;
    assign TDI           = r_tdi;
    assign TRST          = r_trst;
    assign bus.cmd_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_jtag_tap_master.sv
// Directed bench for jtag_tap_master with a behavioural TAP controller on the JTAG pins.
module tb_jtag_tap_master;
    localparam int unsigned DW = 32;

    localparam logic [3:0] TLR = 4'd0,  RTI = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
                           SH_DR = 4'd4, EX1_DR = 4'd5, PA_DR = 4'd6, EX2_DR = 4'd7,
                           UPD_DR = 4'd8, SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR = 4'd11,
                           EX1_IR = 4'd12, PA_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic TCLK, TRST, TMS, TDI;
    logic TDO = 1'b0;

    jtag_tap_master_if #(.DATA_WIDTH(DW)) bus ();

    jtag_tap_master #(.DATA_WIDTH(DW), .CLK_DIV(2)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .TCLK(TCLK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // TAP model state and observation counters
    logic [3:0]  tap = TLR;
    logic [31:0] dr_sr = '0, ir_sr = '0, data_reg = '0, inst_reg = '0;
    int          dr_upd = 0, ir_upd = 0, dr_shifts = 0, tdo_idx = 0;
    int          slot_cnt = 0, rsp_cnt = 0, glitches = 0, run = 2;
    logic [63:0] tms_hist = '0;
    logic        tclk_prev = 1'b0;
    logic [31:0] tdo_pat = '0;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            TLR:    tap_next = m ? TLR    : RTI;
            RTI:    tap_next = m ? SEL_DR : RTI;
            SEL_DR: tap_next = m ? SEL_IR : CAP_DR;
            CAP_DR: tap_next = m ? EX1_DR : SH_DR;
            SH_DR:  tap_next = m ? EX1_DR : SH_DR;
            EX1_DR: tap_next = m ? UPD_DR : PA_DR;
            PA_DR:  tap_next = m ? EX2_DR : PA_DR;
            EX2_DR: tap_next = m ? UPD_DR : SH_DR;
            UPD_DR: tap_next = m ? SEL_DR : RTI;
            SEL_IR: tap_next = m ? TLR    : CAP_IR;
            CAP_IR: tap_next = m ? EX1_IR : SH_IR;
            SH_IR:  tap_next = m ? EX1_IR : SH_IR;
            EX1_IR: tap_next = m ? UPD_IR : PA_IR;
            PA_IR:  tap_next = m ? EX2_IR : PA_IR;
            EX2_IR: tap_next = m ? UPD_IR : SH_IR;
            default: tap_next = m ? SEL_DR : RTI;
        endcase
    endfunction

    always @(posedge TCLK or posedge TRST) begin
        if (TRST) tap <= TLR;
        else begin
            tap <= tap_next(tap, TMS);
            if (tap == SH_DR) begin dr_sr <= {dr_sr[30:0], TDI}; dr_shifts <= dr_shifts + 1; end
            if (tap == SH_IR) ir_sr <= {ir_sr[30:0], TDI};
            if (tap == UPD_DR) begin data_reg <= dr_sr; dr_upd <= dr_upd + 1; end
            if (tap == UPD_IR) begin inst_reg <= ir_sr; ir_upd <= ir_upd + 1; end
        end
    end

    always @(posedge TCLK) begin
        slot_cnt <= slot_cnt + 1;
        tms_hist <= {tms_hist[62:0], TMS};
    end

    // Target drives TDO on the falling TCLK edge while in a shift state
    always @(negedge TCLK) begin
        if (tap == SH_DR || tap == SH_IR) begin
            TDO     <= tdo_pat[31 - tdo_idx];
            tdo_idx <= tdo_idx + 1;
        end else begin
            TDO     <= 1'b0;
            tdo_idx <= 0;
        end
    end

    always @(posedge clk) begin
        if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (TCLK == tclk_prev) run <= run + 1;
        else begin
            if (run < 2) glitches <= glitches + 1;
            run <= 1;
        end
        tclk_prev <= TCLK;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 400) begin tick(1); n++; end
        check(tag, 64'(bus.cmd_ready), 64'd1);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 400) begin tick(1); n++; end
        check(tag, 64'(bus.rsp_valid), 64'd1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        bus.cmd_data  = data;
        wait_ready("issue_ready");
        tick(1);
        bus.cmd_valid = 1'b0;
    endtask

    int s_slot, s_rsp, s_gl, s_upd, s_sh, cnt;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;
        #2 reset_n = 1'b0;
        tick(5);
        // 1: reset values and init sequence
        check("rst_pins_tclk_tms_tdi_trst", {60'd0, TCLK, TMS, TDI, TRST}, 64'b0101);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        s_slot = slot_cnt;
        reset_n = 1'b1;
        tick(1);
        check("init_trst_drop", 64'(TRST), 64'd0);
        cnt = 1;
        while (bus.cmd_ready !== 1'b1 && cnt < 60) begin tick(1); cnt++; end
        check("init_ready_cycle", 64'(cnt), 64'd25);
        check("init_slots", 64'(slot_cnt - s_slot), 64'd6);
        check("init_tms_seq", 64'(tms_hist[5:0]), 64'b111110);
        check("init_tap_idle", 64'(tap), 64'(RTI));

        // 2: DR scan 8 bits of 0xA5
        s_slot = slot_cnt; s_rsp = rsp_cnt; s_upd = dr_upd; s_sh = dr_shifts;
        issue(2'd2, 5'd8, 32'h0000_00A5);
        wait_rsp("dr8_rsp");
        check("dr8_rsp_data", 64'(bus.rsp_data), 64'd0);
        tick(1);
        check("dr8_rsp_pulse_width", 64'(bus.rsp_valid), 64'd0);
        check("dr8_rsp_count", 64'(rsp_cnt - s_rsp), 64'd1);
        check("dr8_slots", 64'(slot_cnt - s_slot), 64'd13);
        check("dr8_tms_seq", 64'(tms_hist[12:0]), 64'h1006);
        check("dr8_shifts", 64'(dr_shifts - s_sh), 64'd8);
        check("dr8_tdi_bits", 64'(data_reg[7:0]), 64'hA5);
        check("dr8_update_count", 64'(dr_upd - s_upd), 64'd1);
        check("dr8_tap_idle", 64'(tap), 64'(RTI));
        check("dr8_idle_pins", {61'd0, TCLK, TMS, TDI}, 64'd0);

        // 3: IR scan, len 0 = full 32 bits
        s_slot = slot_cnt; s_upd = ir_upd;
        issue(2'd1, 5'd0, 32'hDEAD_BEEF);
        wait_rsp("ir32_rsp");
        tick(1);
        check("ir32_slots", 64'(slot_cnt - s_slot), 64'd38);
        check("ir32_tms_seq", 64'(tms_hist[37:0]), 64'({4'b1100, 31'd0, 3'b110}));
        check("ir32_inst_reg", 64'(inst_reg), 64'hDEAD_BEEF);
        check("ir32_update_count", 64'(ir_upd - s_upd), 64'd1);
        check("ir32_tap_idle", 64'(tap), 64'(RTI));

        // 4: TDO capture 0,0,1,1,1,1,0,0
        tdo_pat = 32'h3C00_0000;
        issue(2'd2, 5'd8, 32'h0000_0000);
        wait_rsp("cap8_rsp");
        check("cap8_rsp_data", 64'(bus.rsp_data), 64'h3C);
        tick(2);
        check("cap8_rsp_data_held", 64'(bus.rsp_data), 64'h3C);

        // 5: back-to-back RUN_IDLE 3 then DR_SCAN 4 with cmd_valid held
        tdo_pat = 32'hA000_0000;
        s_slot = slot_cnt; s_rsp = rsp_cnt; s_gl = glitches;
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd3; bus.cmd_len = 5'd3; bus.cmd_data = '0;
        wait_ready("b2b_ready1");
        tick(1);
        bus.cmd_op = 2'd2; bus.cmd_len = 5'd4; bus.cmd_data = 32'h0000_0009;
        wait_rsp("b2b_rsp1");
        check("b2b_run_rsp_zero", 64'(bus.rsp_data), 64'd0);
        check("b2b_ready_in_rsp_cycle", 64'(bus.cmd_ready), 64'd1);
        tick(1);
        bus.cmd_valid = 1'b0;
        check("b2b_second_accepted", 64'(bus.cmd_ready), 64'd0);
        check("b2b_run_slots", 64'(slot_cnt - s_slot), 64'd3);
        wait_rsp("b2b_rsp2");
        check("b2b_dr4_rsp_data", 64'(bus.rsp_data), 64'hA);
        tick(1);
        check("b2b_rsp_count", 64'(rsp_cnt - s_rsp), 64'd2);
        check("b2b_slots", 64'(slot_cnt - s_slot), 64'd12);
        check("b2b_tms_seq", 64'(tms_hist[11:0]), 64'b000100000110);
        check("b2b_dr4_data", 64'(data_reg[3:0]), 64'h9);
        check("b2b_no_tclk_glitch", 64'(glitches - s_gl), 64'd0);

        // 6: reset during DR shift slot 5 of 8, then init reruns
        tdo_pat = 32'h0;
        s_sh = dr_shifts; s_rsp = rsp_cnt;
        issue(2'd2, 5'd8, 32'h0000_005A);
        cnt = 0;
        while ((dr_shifts - s_sh) < 4 && cnt < 200) begin tick(1); cnt++; end
        while (TCLK !== 1'b0 && cnt < 200) begin tick(1); cnt++; end
        check("abort_reached_slot5", 64'(dr_shifts - s_sh), 64'd4);
        tick(1);
        reset_n = 1'b0;
        #1;
        check("abort_pins_tclk_tms_trst", {61'd0, TCLK, TMS, TRST}, 64'b011);
        check("abort_ready_low", 64'(bus.cmd_ready), 64'd0);
        tick(3);
        s_slot = slot_cnt;
        reset_n = 1'b1;
        cnt = 0;
        while (bus.cmd_ready !== 1'b1 && cnt < 60) begin tick(1); cnt++; end
        check("reinit_ready_cycle", 64'(cnt), 64'd25);
        check("reinit_tms_seq", 64'(tms_hist[5:0]), 64'b111110);
        check("reinit_slots", 64'(slot_cnt - s_slot), 64'd6);
        check("reinit_tap_idle", 64'(tap), 64'(RTI));
        check("abort_no_rsp", 64'(rsp_cnt - s_rsp), 64'd0);
        tdo_pat = 32'h8100_0000;
        issue(2'd2, 5'd8, 32'h0000_003C);
        wait_rsp("post_abort_rsp");
        check("post_abort_rsp_data", 64'(bus.rsp_data), 64'h81);
        tick(1);
        check("post_abort_data_reg", 64'(data_reg[7:0]), 64'h3C);
        check("post_abort_tap_idle", 64'(tap), 64'(RTI));

        // 7: TAP_RESET command holds TRST and returns zero
        s_slot = slot_cnt;
        issue(2'd0, 5'd0, 32'hFFFF_FFFF);
        tick(2);
        check("tapreset_trst_high", 64'(TRST), 64'd1);
        wait_rsp("tapreset_rsp");
        check("tapreset_rsp_zero", 64'(bus.rsp_data), 64'd0);
        check("tapreset_trst_released", 64'(TRST), 64'd0);
        check("tapreset_slots", 64'(slot_cnt - s_slot), 64'd6);
        check("tapreset_tms_seq", 64'(tms_hist[5:0]), 64'b111110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
